ntt_ct_butterfly: RTL and testbench
===================================

NTT_CT_BUTTERFLY -- requirements
Module: ntt_ct_butterfly

Interface
REQ-001 SHALL have parameters: KYBER_Q, default 3329, modulus; TAG_W, default 8, coefficient-index tag width.
REQ-002 SHALL have ports, in order:
  - clk  in  1  clock, rising edge.
  - rst_n  in  1  asynchronous active-low reset.
  - in_valid  in  1  operand beat valid.
  - in_ready  out  1  block accepts beat.
  - in_a  in  16  signed coefficient a.
  - in_b  in  16  signed coefficient b.
  - in_zeta  in  16  signed twiddle, Montgomery domain.
  - in_tag  in  TAG_W  index tag, passed through unchanged.
  - out_valid  out  1  result valid.
  - out_ready  in  1  downstream accepts.
  - out_a  out  16  signed a + t.
  - out_b  out  16  signed a - t.
  - out_tag  out  TAG_W  tag of the result.
  - busy  out  1  any pipeline stage holds a beat.
REQ-003 SHALL use one clock; reset is asynchronous, active-low.

Function
REQ-004 SHALL run a Cooley-Tukey butterfly: t = montgomery_reduce(b*zeta); out_a = a+t; out_b = a-t.
REQ-005 SHALL run as a pipeline:
  - S1 registers p = in_b*in_zeta, a full 32-bit signed product, together with a and tag.
  - S2 registers t: t16 = low16(p*QINV) with QINV = -3327; t = (p - t16*KYBER_Q)[31:16].
  - S3 registers out_a and out_b.
REQ-006 SHALL compute out_a/out_b as 16-bit two's-complement sums; overflow wraps and is not flagged.
REQ-007 SHALL have latency 3 cycles from the accepting edge to out_valid when there is no stall; throughput is 1 beat per cycle.
REQ-008 SHALL give each stage its own valid bit; a stage loads when it is empty or its contents move downstream in the same cycle (bubble collapsing).
REQ-009 SHALL define the last stage as advancing when out_valid && out_ready; in_ready = !S1_valid || S1 advancing.
REQ-010 SHALL accept a beat only when in_valid && in_ready; when out_valid && !out_ready, out_* SHALL hold stable.
REQ-011 SHALL handle simultaneous accept and emit in one cycle with no bubble and no beat loss.
REQ-012 SHALL never drop, duplicate or reorder beats; out_tag follows its operands.
REQ-013 SHALL drive busy as the OR of all stage valid bits.

Reset
REQ-014 SHALL, on rst_n low, clear all stage valids immediately: out_valid=0, busy=0, in_ready=1 after reset.
REQ-015 SHALL reset out_a/out_b/out_tag and datapath registers to 0.
REQ-016 SHALL discard in-flight beats on reset mid-operation; none reappear after release.

Configuration
REQ-017 SHALL use macro NTT_BF_BARRETT_EN; when defined, S4 is added with latency 4.
  - S4 Barrett-reduces out_a and out_b: v = 20159; r = x - ((v*x + 2^25) >>> 26)*KYBER_Q.
  - Results are centered representatives of x mod q.
REQ-018 SHALL, when NTT_BF_BARRETT_EN is undefined, have no S4: latency 3, unreduced outputs.

Structure
REQ-019 SHALL place KYBER_Q, QINV (-3327), MONT (-1044) and BARRETT_V (20159) in shared package ntt_pkg.
REQ-020 SHALL place the S2 reduction in the existing combinational 32->16 Montgomery reduction sub-module mont_reduce; the Barrett step SHALL be sub-module barrett_reduce.

Verification
REQ-021 SHALL have a bench covering these directed scenarios:
  - a=100, b=1, zeta=1 -> t=169, out_a=269, out_b=-69, 3 cycles later.
  - a=10, b=5, zeta=-1044 -> t=5, out_a=15, out_b=5.
  - a=1234, b=0, any zeta -> out_a=out_b=1234; tags 0..255 streamed back-to-back with out_ready=1 -> one result per cycle, tags in order.
  - out_ready held 0 for 5 cycles with 4 beats offered -> in_ready drops once 3 (4 with Barrett) are held; outputs stable; none lost after release.
  - rst_n pulsed low while 2 beats are in flight -> out_valid=0 and busy=0 at once; no stale output after release.
  - NTT_BF_BARRETT_EN defined: a=3329, b=0 -> out_a=0, out_b=0, latency 4.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants for the Kyber NTT datapath.
package ntt_pkg;

    localparam int KYBER_Q   = 3329;
    // q^-1 mod 2^16, signed representative
    localparam int QINV      = -3327;
    // 2^16 mod q, signed representative (Montgomery factor)
    localparam int MONT      = -1044;
    // round(2^26 / q)
    localparam int BARRETT_V = 20159;

endpackage

// File: rtl/barrett_reduce.sv
// Combinational 16-bit Barrett reduction to the centered representative mod Q.
module barrett_reduce
    import ntt_pkg::*;
#(
    parameter int Q = 3329
) (
    input  logic signed [15:0] x_i,
    output logic signed [15:0] r_o
);

    logic signed [31:0] x_ext;
    logic signed [31:0] quot;

    // Rounded quotient x/Q via the 2^26-scaled reciprocal.
    always_comb begin
        x_ext = {{16{x_i[15]}}, x_i};
        quot  = (x_ext * BARRETT_V + 32'sd33554432) >>> 26;
        r_o   = 16'(x_ext - quot * Q);
    end

endmodule

// File: rtl/mont_reduce.sv
// Combinational 32->16 Montgomery reduction: t = (p - low16(p*QINV)*Q) >> 16.
module mont_reduce
    import ntt_pkg::*;
#(
    parameter int Q = 3329
) (
    input  logic signed [31:0] p_i,
    output logic signed [15:0] t_o
);

    logic signed [15:0] m_lo;
    logic signed [31:0] m_ext;
    logic signed [31:0] diff;

    // Low half of p*QINV makes the low 16 bits of (p - m*Q) vanish.
    always_comb begin
        m_lo  = 16'(p_i * QINV);
        m_ext = {{16{m_lo[15]}}, m_lo};
        diff  = p_i - m_ext * Q;
        t_o   = 16'(diff >>> 16);
    end

endmodule

// File: rtl/ntt_ct_butterfly.sv
// Pipelined Cooley-Tukey butterfly: t = mont(b*zeta); out_a = a+t; out_b = a-t.
// Optional macro NTT_BF_BARRETT_EN adds a fourth stage that Barrett-reduces both outputs.
module ntt_ct_butterfly #(
    parameter int KYBER_Q = 3329,
    parameter int TAG_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_a,
    input  logic signed [15:0]      in_b,
    input  logic signed [15:0]      in_zeta,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [15:0]      out_a,
    output logic signed [15:0]      out_b,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    busy
);

    logic                    s1_v_q, s1_v_d, s1_rdy;
    logic signed [31:0]      s1_p_q, s1_p_d;
    logic signed [15:0]      s1_a_q, s1_a_d;
    logic [TAG_W-1:0]        s1_tag_q, s1_tag_d;

    logic                    s2_v_q, s2_v_d, s2_rdy;
    logic signed [15:0]      s2_t_q, s2_t_d;
    logic signed [15:0]      s2_a_q, s2_a_d;
    logic [TAG_W-1:0]        s2_tag_q, s2_tag_d;

    logic                    s3_v_q, s3_v_d, s3_rdy;
    logic signed [15:0]      s3_a_q, s3_a_d;
    logic signed [15:0]      s3_b_q, s3_b_d;
    logic [TAG_W-1:0]        s3_tag_q, s3_tag_d;

    logic signed [15:0]      mont_t;

    mont_reduce #(
        .Q (KYBER_Q)
    ) u_mont (
        .p_i (s1_p_q),
        .t_o (mont_t)
    );

`ifdef NTT_BF_BARRETT_EN
    logic                    s4_v_q, s4_v_d, s4_rdy;
    logic signed [15:0]      s4_a_q, s4_a_d;
    logic signed [15:0]      s4_b_q, s4_b_d;
    logic [TAG_W-1:0]        s4_tag_q, s4_tag_d;
    logic signed [15:0]      red_a, red_b;

    barrett_reduce #(
        .Q (KYBER_Q)
    ) u_bar_a (
        .x_i (s3_a_q),
        .r_o (red_a)
    );

    barrett_reduce #(
        .Q (KYBER_Q)
    ) u_bar_b (
        .x_i (s3_b_q),
        .r_o (red_b)
    );
`endif

    // Ready chain: a stage may load when empty or when its beat moves on this cycle.
    always_comb begin
`ifdef NTT_BF_BARRETT_EN
        s4_rdy = !s4_v_q || out_ready;
        s3_rdy = !s3_v_q || s4_rdy;
`else
        s3_rdy = !s3_v_q || out_ready;
`endif
        s2_rdy = !s2_v_q || s3_rdy;
        s1_rdy = !s1_v_q || s2_rdy;
    end

    // Next-state for every stage; data registers only load alongside a valid beat.
    always_comb begin
        s1_v_d   = s1_rdy ? in_valid : s1_v_q;
        s1_p_d   = s1_p_q;
        s1_a_d   = s1_a_q;
        s1_tag_d = s1_tag_q;
        if (s1_rdy && in_valid) begin
            s1_p_d   = in_b * in_zeta;
            s1_a_d   = in_a;
            s1_tag_d = in_tag;
        end

        s2_v_d   = s2_rdy ? s1_v_q : s2_v_q;
        s2_t_d   = s2_t_q;
        s2_a_d   = s2_a_q;
        s2_tag_d = s2_tag_q;
        if (s2_rdy && s1_v_q) begin
            s2_t_d   = mont_t;
            s2_a_d   = s1_a_q;
            s2_tag_d = s1_tag_q;
        end

        s3_v_d   = s3_rdy ? s2_v_q : s3_v_q;
        s3_a_d   = s3_a_q;
        s3_b_d   = s3_b_q;
        s3_tag_d = s3_tag_q;
        if (s3_rdy && s2_v_q) begin
            s3_a_d   = s2_a_q + s2_t_q;
            s3_b_d   = s2_a_q - s2_t_q;
            s3_tag_d = s2_tag_q;
        end

`ifdef NTT_BF_BARRETT_EN
        s4_v_d   = s4_rdy ? s3_v_q : s4_v_q;
        s4_a_d   = s4_a_q;
        s4_b_d   = s4_b_q;
        s4_tag_d = s4_tag_q;
        if (s4_rdy && s3_v_q) begin
            s4_a_d   = red_a;
            s4_b_d   = red_b;
            s4_tag_d = s3_tag_q;
        end
`endif
    end

    // Pipeline state; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q   <= 1'b0;
            s1_p_q   <= '0;
            s1_a_q   <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_t_q   <= '0;
            s2_a_q   <= '0;
            s2_tag_q <= '0;
            s3_v_q   <= 1'b0;
            s3_a_q   <= '0;
            s3_b_q   <= '0;
            s3_tag_q <= '0;
`ifdef NTT_BF_BARRETT_EN
            s4_v_q   <= 1'b0;
            s4_a_q   <= '0;
            s4_b_q   <= '0;
            s4_tag_q <= '0;
`endif
        end else begin
            s1_v_q   <= s1_v_d;
            s1_p_q   <= s1_p_d;
            s1_a_q   <= s1_a_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_t_q   <= s2_t_d;
            s2_a_q   <= s2_a_d;
            s2_tag_q <= s2_tag_d;
            s3_v_q   <= s3_v_d;
            s3_a_q   <= s3_a_d;
            s3_b_q   <= s3_b_d;
            s3_tag_q <= s3_tag_d;
`ifdef NTT_BF_BARRETT_EN
            s4_v_q   <= s4_v_d;
            s4_a_q   <= s4_a_d;
            s4_b_q   <= s4_b_d;
            s4_tag_q <= s4_tag_d;
`endif
        end
    end

    // Outputs come straight from the last stage registers.
    always_comb begin
        in_ready = s1_rdy;
`ifdef NTT_BF_BARRETT_EN
        out_valid = s4_v_q;
        out_a     = s4_a_q;
        out_b     = s4_b_q;
        out_tag   = s4_tag_q;
        busy      = s1_v_q || s2_v_q || s3_v_q || s4_v_q;
`else
        out_valid = s3_v_q;
        out_a     = s3_a_q;
        out_b     = s3_b_q;
        out_tag   = s3_tag_q;
        busy      = s1_v_q || s2_v_q || s3_v_q;
`endif
    end

endmodule

// File: tb/tb_ntt_ct_butterfly.sv
// Scoreboard bench for ntt_ct_butterfly; honours NTT_BF_BARRETT_EN like the RTL.
module tb_ntt_ct_butterfly;

`ifdef NTT_BF_BARRETT_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_a = '0;
    logic signed [15:0] in_b = '0;
    logic signed [15:0] in_zeta = '0;
    logic [7:0]         in_tag = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic signed [15:0] out_a;
    logic signed [15:0] out_b;
    logic [7:0]         out_tag;
    logic               busy;

    ntt_ct_butterfly #(
        .KYBER_Q (3329),
        .TAG_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_zeta   (in_zeta),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  tag;
        logic [15:0] a;
        logic [15:0] b;
        logic        stream;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   first_c = -1;
    int   last_c = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Montgomery reduction by its definition: t = (p - m*q) / 2^16, m = p*q^-1 mod 2^16 centered.
    function automatic int mont_ref(input int p);
        longint m;
        m = ((longint'(p) * -3327) % 65536 + 65536) % 65536;
        if (m >= 32768) m = m - 65536;
        return int'((longint'(p) - m * 3329) / 65536);
    endfunction

    function automatic int wrap16(input int x);
        int r;
        r = ((x + 32768) % 65536 + 65536) % 65536;
        return r - 32768;
    endfunction

    function automatic int centered(input int x);
        int r;
        r = ((x % 3329) + 3329) % 3329;
        if (r > 1664) r = r - 3329;
        return r;
    endfunction

    function automatic exp_t model(input int a, input int b, input int z, input logic [7:0] tag);
        exp_t e;
        int   t, sa, sd;
        t  = mont_ref(b * z);
        sa = wrap16(a + t);
        sd = wrap16(a - t);
`ifdef NTT_BF_BARRETT_EN
        sa = centered(sa);
        sd = centered(sd);
`endif
        e.tag    = tag;
        e.a      = 16'(sa);
        e.b      = 16'(sd);
        e.stream = 1'b0;
        return e;
    endfunction

    function automatic int rnd16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // One cycle of stimulus: drive at negedge, decide acceptance just before the rising edge.
    task automatic drive(input logic v, input int a, input int b, input int z,
                         input logic [7:0] tag, input logic orr, input logic strm,
                         output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = 16'(a);
        in_b      = 16'(b);
        in_zeta   = 16'(z);
        in_tag    = tag;
        out_ready = orr;
        #4;
        acc = v && in_ready;
        if (acc) begin
            e        = model(a, b, z, tag);
            e.stream = strm;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    // Directed beat with hand-derived expected results.
    task automatic send_dir(input int a, input int b, input int z, input logic [7:0] tag,
                            input int ea, input int eb);
        logic acc;
        exp_t e;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive(1'b1, a, b, z, tag, 1'b1, 1'b0, acc);
        if (!acc) begin
            chk("dir_accept", 32'(acc), 32'd1);
        end else begin
            e   = sb.pop_back();
            e.a = 16'(ea);
            e.b = 16'(eb);
            sb.push_back(e);
        end
    endtask

    // Counts edges from the accepting edge (inclusive) until out_valid is seen.
    task automatic measure_lat(input string name);
        int lat;
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #3;
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        chk(name, 32'(lat), 32'(LAT));
    endtask

    task automatic drain(input string name);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #4;
        chk(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pops on every handshake and checks that stalled outputs hold.
    logic        hold_prev = 1'b0;
    logic [15:0] pa, pb;
    logic [7:0]  pt;
    exp_t        mon_e;

    always @(negedge clk) begin
        #3;
        if (rst_n && out_valid) begin
            if (hold_prev) begin
                chk("hold_a", {16'd0, out_a}, {16'd0, pa});
                chk("hold_b", {16'd0, out_b}, {16'd0, pb});
                chk("hold_tag", {24'd0, out_tag}, {24'd0, pt});
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got tag %0d, required no output", out_tag);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_tag", {24'd0, out_tag}, {24'd0, mon_e.tag});
                    chk("out_a", {16'd0, out_a}, {16'd0, mon_e.a});
                    chk("out_b", {16'd0, out_b}, {16'd0, mon_e.b});
                    if (mon_e.stream && mon_e.tag == 8'd0) first_c = cyc;
                    if (mon_e.stream && mon_e.tag == 8'd255) last_c = cyc;
                end
            end
            hold_prev = !out_ready;
            pa = out_a;
            pb = out_b;
            pt = out_tag;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        int   idx;
        int   stalls;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_a", {16'd0, out_a}, 32'd0);
        chk("rst_out_b", {16'd0, out_b}, 32'd0);
        chk("rst_out_tag", {24'd0, out_tag}, 32'd0);
        rst_n = 1'b1;

        // t = 169 for b*zeta = 1
        send_dir(100, 1, 1, 8'd1, 269, -69);
        measure_lat("latency_d1");
        drain("drain_d1");

        // zeta = MONT maps b back to itself
        send_dir(10, 5, -1044, 8'd2, 15, 5);
        measure_lat("latency_d2");
        drain("drain_d2");

        // Back-to-back stream, b = 0
        stalls = 0;
        for (int t = 0; t < 256; t++) begin
            acc = 1'b0;
            for (int k = 0; k < 10 && !acc; k++) begin
                drive(1'b1, 1234, 0, rnd16(), 8'(t), 1'b1, 1'b1, acc);
                if (!acc) stalls++;
            end
        end
        drain("drain_stream");
        chk("stream_stalls", 32'(stalls), 32'd0);
        chk("stream_spacing", 32'(last_c - first_c), 32'd255);

        // Output stall with four beats offered
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(idx < 4, rnd16(), rnd16(), rnd16(), 8'(100 + idx), 1'b0, 1'b0, acc);
            if (acc) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'(LAT));
        @(negedge clk);
        #3;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        for (int k = 0; k < 20 && idx < 4; k++) begin
            drive(1'b1, rnd16(), rnd16(), rnd16(), 8'(100 + idx), 1'b1, 1'b0, acc);
            if (acc) idx++;
        end
        drain("drain_stall");

        // Reset with two beats in flight
        drive(1'b1, 7, 3, 17, 8'd200, 1'b1, 1'b0, acc);
        drive(1'b1, 8, 4, 18, 8'd201, 1'b1, 1'b0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        #1;
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // a = q, b = 0: reduced to 0 only when the Barrett stage exists
`ifdef NTT_BF_BARRETT_EN
        send_dir(3329, 0, 99, 8'd3, 0, 0);
`else
        send_dir(3329, 0, 99, 8'd3, 3329, 3329);
`endif
        measure_lat("latency_q");
        drain("drain_q");

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, rnd16(), rnd16(), rnd16(), 8'(i),
                  ($urandom % 4) != 0, 1'b0, acc);
        end
        drain("drain_random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
